stim_sequencer: RTL

STIM_SEQUENCER -- requirements
Module: stim_sequencer

---
 rtl/stim_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/stim_sequencer.sv
// Coil stimulation sequencer: prioritised triggers drive one active-low coil pulse, then cooldown.
// Optional macro STIM_PENDING_EN latches SW/RFID/flame triggers seen while busy.
module stim_sequencer #(
  parameter int unsigned      N_CH      = 5,
  parameter int unsigned      LEN_W     = 10,
  parameter logic [LEN_W-1:0] PULSE_LEN = 10'd3,
  parameter logic [LEN_W-1:0] COOLDOWN  = 10'd2,
  parameter int unsigned      FLAME_CH  = 2,
  localparam int unsigned     CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  sw,
  input  logic             rfid_valid,
  input  logic [N_CH-1:0]  rfid_ch,
  input  logic             flame,
  input  logic             req_valid,
  input  logic [CH_W-1:0]  req_ch,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  output logic [N_CH-1:0]  coil,
  output logic             busy,
  output logic [CH_W-1:0]  active_ch,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {StIdle = 2'd0, StPulse = 2'd1, StCool = 2'd2} state_e;

  localparam logic [LEN_W-1:0] DefLen = (PULSE_LEN == '0) ? LEN_W'(1) : PULSE_LEN;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [N_CH-1:0]  coil_q, coil_d;
  logic             busy_q;
  logic [1:0]       flame_hist_q;
  logic             flame_trig;
  logic             rfid_hit;
  logic             start;
  logic [CH_W-1:0]  start_ch;
  logic [LEN_W-1:0] start_len;

  function automatic logic [CH_W-1:0] low_idx(input logic [N_CH-1:0] v);
    low_idx = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (v[i]) low_idx = CH_W'(i);
    end
  endfunction

  assign flame_trig = &flame_hist_q;
  assign rfid_hit   = rfid_valid && (|rfid_ch);

`ifdef STIM_PENDING_EN
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] trig_vec;

  always_comb begin
    trig_vec = sw;
    if (rfid_hit)   trig_vec[low_idx(rfid_ch)] = 1'b1;
    if (flame_trig) trig_vec[FLAME_CH] = 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ch_d      = ch_q;
    start     = 1'b0;
    start_ch  = '0;
    start_len = DefLen;
`ifdef STIM_PENDING_EN
    pend_d    = pend_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          // Out-of-range channel: handshake completes, nothing fires.
          if (int'(req_ch) < N_CH) begin
            start     = 1'b1;
            start_ch  = req_ch;
            start_len = (req_len == '0) ? LEN_W'(1) : req_len;
          end
        end else if (flame_trig) begin
          start    = 1'b1;
          start_ch = CH_W'(FLAME_CH);
`ifdef STIM_PENDING_EN
        end else if (|pend_q) begin
          start    = 1'b1;
          start_ch = low_idx(pend_q);
          pend_d[low_idx(pend_q)] = 1'b0;
`endif
        end else if (rfid_hit) begin
          start    = 1'b1;
          start_ch = low_idx(rfid_ch);
        end else if (|sw) begin
          start    = 1'b1;
          start_ch = low_idx(sw);
        end
      end
      StPulse: begin
        if (cnt_q == len_q - 1'b1) begin
          cnt_d   = '0;
          state_d = (COOLDOWN == '0) ? StIdle : StCool;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCool: begin
        if (cnt_q == LEN_W'(COOLDOWN - 1'b1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d = StPulse;
      cnt_d   = '0;
      len_d   = start_len;
      ch_d    = start_ch;
    end

`ifdef STIM_PENDING_EN
    if (state_q != StIdle) pend_d = pend_d | trig_vec;
`endif

    coil_d = '1;
    if (state_d == StPulse) coil_d[ch_d] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      len_q        <= DefLen;
      ch_q         <= '0;
      coil_q       <= '1;
      busy_q       <= 1'b0;
      flame_hist_q <= '0;
`ifdef STIM_PENDING_EN
      pend_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      ch_q         <= ch_d;
      coil_q       <= coil_d;
      busy_q       <= (state_d != StIdle);
      flame_hist_q <= {flame_hist_q[0], flame};
`ifdef STIM_PENDING_EN
      pend_q       <= pend_d;
`endif
    end
  end

  assign req_ready = (state_q == StIdle) && !reset;
  assign coil      = coil_q;
  assign busy      = busy_q;
  assign active_ch = ch_q;
  assign state     = state_q;

endmodule
